// File: rtl/fifo_exerciser_pkg.sv
// Shared types and command bytes for the UART-driven FIFO exerciser.
package fifo_exerciser_pkg;

  localparam logic [7:0] CMD_FILL_ALL = 8'h77;  // 'w'
  localparam logic [7:0] CMD_FILL_N   = 8'h6E;  // 'n'
  localparam logic [7:0] CMD_DRAIN    = 8'h72;  // 'r'
  localparam logic [7:0] CMD_CHECK    = 8'h63;  // 'c'
  localparam logic [7:0] CMD_MODE     = 8'h6D;  // 'm'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ARG,
    ST_FILL_ALL,
    ST_FILL_N,
    ST_DRAIN,
    ST_CHECK,
    ST_REPORT
  } state_e;

  typedef enum logic {PAT_COUNTER, PAT_LFSR} pat_mode_e;

  typedef enum logic {ARG_COUNT, ARG_MODE} arg_kind_e;

endpackage

// File: rtl/fifo_pattern_gen.sv
// Counter / Galois-LFSR pattern source shared by the fill and check paths.
module fifo_pattern_gen
  import fifo_exerciser_pkg::*;
#(
  parameter int                   DATA_BITS = 8,
  parameter logic [DATA_BITS-1:0] LFSR_TAPS = 'hB8,
  parameter logic [DATA_BITS-1:0] LFSR_SEED = 1
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 load,
  input  logic                 adv,
  input  pat_mode_e            mode,
  output logic [DATA_BITS-1:0] pat
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [DATA_BITS-1:0] SEED =
    (LFSR_SEED == '0) ? DATA_BITS'(1) : LFSR_SEED;

  logic [DATA_BITS-1:0] pat_q, pat_d;

  always_comb begin
    pat_d = pat_q;
    if (load) begin
      pat_d = (mode == PAT_LFSR) ? SEED : '0;
    end else if (adv) begin
      if (mode == PAT_LFSR) pat_d = (pat_q >> 1) ^ (pat_q[0] ? LFSR_TAPS : '0);
      else                  pat_d = pat_q + DATA_BITS'(1);
    end
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) pat_q <= '0;
    else        pat_q <= pat_d;
  end

  assign pat = pat_q;

endmodule

// File: rtl/fifo_exerciser.sv
// Command FSM that fills, drains and self-checks a show-ahead FIFO from UART bytes.
//   state     | meaning
//   IDLE      | waiting for a command byte
//   GET_ARG   | waiting for the argument of 'n' or 'm'
//   FILL_ALL  | writing pattern until full
//   FILL_N    | writing pattern for the remaining count or until full
//   DRAIN     | popping words out to the UART as it becomes ready
//   CHECK     | popping words and comparing against the regenerated pattern
//   REPORT    | sending err_count once the UART is ready
module fifo_exerciser
  import fifo_exerciser_pkg::*;
#(
  parameter int                   DATA_BITS = 8,
  parameter int                   CNT_BITS  = 8,
  parameter logic [DATA_BITS-1:0] LFSR_TAPS = 'hB8,
  parameter logic [DATA_BITS-1:0] LFSR_SEED = 1
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 uart_rx_valid_in,
  input  logic [7:0]           uart_rx_data_in,
  input  logic                 uart_tx_ready_in,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data_out,
  input  logic                 fifo_full_in,
  input  logic                 fifo_empty_in,
  input  logic [DATA_BITS-1:0] fifo_rd_data_in,
  output logic                 fifo_wr_en,
  output logic [DATA_BITS-1:0] fifo_wr_data_out,
  output logic                 fifo_rd_en,
  output logic                 busy,
  output logic                 cmd_drop,
  output logic [7:0]           err_count
);

  localparam int RB = (DATA_BITS < 8) ? DATA_BITS : 8;

  state_e              state_q, state_d;
  pat_mode_e           mode_q, mode_d;
  arg_kind_e           arg_q, arg_d;
  logic [CNT_BITS-1:0] rem_q, rem_d;
  logic [7:0]          err_q, err_d;
  logic                pat_load, pat_adv;
  logic [DATA_BITS-1:0] pat;
  logic [7:0]          rd_byte;
  logic                cmd_known;

  assign rd_byte   = 8'(fifo_rd_data_in[RB-1:0]);
  assign cmd_known = uart_rx_data_in inside {CMD_FILL_ALL, CMD_FILL_N, CMD_DRAIN,
                                             CMD_CHECK, CMD_MODE};
  assign pat_adv   = fifo_wr_en || (state_q == ST_CHECK && fifo_rd_en);

  fifo_pattern_gen #(
    .DATA_BITS (DATA_BITS),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) u_pat (
    .clk_in (clk_in),
    .n_rst  (n_rst),
    .load   (pat_load),
    .adv    (pat_adv),
    .mode   (mode_q),
    .pat    (pat)
  );

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= PAT_COUNTER;
      arg_q   <= ARG_COUNT;
      rem_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    arg_d    = arg_q;
    rem_d    = rem_q;
    err_d    = err_q;
    pat_load = 1'b0;
    unique case (state_q)
      ST_IDLE: if (uart_rx_valid_in) begin
        unique case (uart_rx_data_in)
          CMD_FILL_ALL: begin state_d = ST_FILL_ALL; pat_load = 1'b1; end
          CMD_FILL_N:   begin state_d = ST_GET_ARG;  arg_d = ARG_COUNT; end
          CMD_DRAIN:    state_d = ST_DRAIN;
          CMD_CHECK:    begin state_d = ST_CHECK; pat_load = 1'b1; err_d = '0; end
          CMD_MODE:     begin state_d = ST_GET_ARG;  arg_d = ARG_MODE; end
          default:      ;
        endcase
      end
      ST_GET_ARG: if (uart_rx_valid_in) begin
        if (arg_q == ARG_MODE) begin
          mode_d  = pat_mode_e'(uart_rx_data_in[0]);
          state_d = ST_IDLE;
        end else begin
          rem_d = uart_rx_data_in[CNT_BITS-1:0];
          if (uart_rx_data_in[CNT_BITS-1:0] == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_FILL_N;
            pat_load = 1'b1;
          end
        end
      end
      ST_FILL_ALL: if (fifo_full_in) state_d = ST_IDLE;
      ST_FILL_N: begin
        if (fifo_full_in) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_q - CNT_BITS'(1);
          if (rem_q == CNT_BITS'(1)) state_d = ST_IDLE;
        end
      end
      ST_DRAIN: if (fifo_empty_in) state_d = ST_IDLE;
      ST_CHECK: begin
        if (fifo_empty_in) state_d = ST_REPORT;
        else if (fifo_rd_data_in != pat && err_q != 8'hFF) err_d = err_q + 8'd1;
      end
      ST_REPORT: if (uart_tx_ready_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    uart_tx_en       = 1'b0;
    uart_tx_data_out = '0;
    fifo_wr_en       = 1'b0;
    fifo_wr_data_out = '0;
    fifo_rd_en       = 1'b0;
    busy             = (state_q != ST_IDLE);
    cmd_drop         = 1'b0;
    if (uart_rx_valid_in) begin
      if (state_q == ST_IDLE)          cmd_drop = !cmd_known;
      else if (state_q != ST_GET_ARG)  cmd_drop = 1'b1;
    end
    unique case (state_q)
      ST_FILL_ALL, ST_FILL_N: if (!fifo_full_in) begin
        fifo_wr_en       = 1'b1;
        fifo_wr_data_out = pat;
      end
      ST_DRAIN: if (!fifo_empty_in && uart_tx_ready_in) begin
        fifo_rd_en       = 1'b1;
        uart_tx_en       = 1'b1;
        uart_tx_data_out = rd_byte;
      end
      ST_CHECK: fifo_rd_en = !fifo_empty_in;
      ST_REPORT: if (uart_tx_ready_in) begin
        uart_tx_en       = 1'b1;
        uart_tx_data_out = err_q;
      end
      default: ;
    endcase
  end

  assign err_count = err_q;

endmodule

// File: tb/tb_fifo_exerciser.sv
// Directed bench: depth-4 show-ahead FIFO model plus UART byte stimulus.
module tb_fifo_exerciser;

  logic       clk_in = 1'b0;
  logic       n_rst  = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rdy_fix = 1'b1, tog_en = 1'b0, tog_q = 1'b0;
  logic       tx_ready;
  logic       tx_en, wr_en, rd_en, busy, cmd_drop;
  logic [7:0] tx_data, wr_data, err_count;
  logic       fifo_full, fifo_empty;
  logic [7:0] rd_data;
  logic       tb_flush = 1'b0, tb_corrupt = 1'b0;

  logic [7:0] fm [0:3];
  int         fcnt = 0;
  int         pop_cnt = 0, nr_cnt = 0;
  logic [7:0] wr_log [$];
  logic [7:0] tx_log [$];
  int         total = 0, bad = 0;

  always #5 clk_in = ~clk_in;
  always @(negedge clk_in) tog_q <= ~tog_q;

  assign tx_ready   = tog_en ? tog_q : rdy_fix;
  assign fifo_full  = (fcnt == 4);
  assign fifo_empty = (fcnt == 0);
  assign rd_data    = fm[0];

  fifo_exerciser dut (
    .clk_in           (clk_in),
    .n_rst            (n_rst),
    .uart_rx_valid_in (rx_valid),
    .uart_rx_data_in  (rx_data),
    .uart_tx_ready_in (tx_ready),
    .uart_tx_en       (tx_en),
    .uart_tx_data_out (tx_data),
    .fifo_full_in     (fifo_full),
    .fifo_empty_in    (fifo_empty),
    .fifo_rd_data_in  (rd_data),
    .fifo_wr_en       (wr_en),
    .fifo_wr_data_out (wr_data),
    .fifo_rd_en       (rd_en),
    .busy             (busy),
    .cmd_drop         (cmd_drop),
    .err_count        (err_count)
  );

  // FIFO model: pop shifts toward fm[0], push lands behind the last valid word.
  always @(posedge clk_in) begin
    if (tb_flush) begin
      fcnt <= 0;
    end else if (tb_corrupt) begin
      fm[2] <= 8'hFF;
    end else begin
      if (rd_en && fcnt > 0) begin
        for (int i = 0; i < 3; i++) fm[i] <= fm[i+1];
        pop_cnt <= pop_cnt + 1;
      end
      if (wr_en && fcnt < 4) begin
        fm[(rd_en && fcnt > 0) ? fcnt - 1 : fcnt] <= wr_data;
        wr_log.push_back(wr_data);
      end
      fcnt <= fcnt + ((wr_en && fcnt < 4) ? 1 : 0) - ((rd_en && fcnt > 0) ? 1 : 0);
    end
    if (tx_en) tx_log.push_back(tx_data);
    if (rd_en && !tx_ready) nr_cnt <= nr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic drop);
    @(negedge clk_in);
    rx_valid = 1'b1;
    rx_data  = b;
    #1 drop = cmd_drop;
    @(negedge clk_in);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic pulse_flush();
    @(negedge clk_in); tb_flush = 1'b1;
    @(negedge clk_in); tb_flush = 1'b0;
  endtask

  task automatic check_wr(input string tag, input int w0, input int n, input logic [7:0] e0,
                          input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp [0:3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    chk({tag, "_nwr"}, wr_log.size() - w0, n);
    for (int i = 0; i < n && i < 4; i++)
      if (w0 + i < wr_log.size()) chk($sformatf("%s_wr%0d", tag, i), wr_log[w0+i], exp[i]);
  endtask

  initial begin
    logic drop;
    int   w0, t0, p0, r0;

    // reset state
    repeat (2) @(negedge clk_in);
    #1 chk("rst_outs", {tx_en, tx_data, wr_en, wr_data, rd_en, busy, cmd_drop, err_count}, 0);
    @(negedge clk_in); n_rst = 1'b1;
    #1 chk("rst_busy", busy, 0);

    // 1: fill until full
    w0 = wr_log.size();
    send_byte(8'h77, drop);
    chk("w_drop", drop, 0);
    chk("w_busy", busy, 1);
    wait_idle("fill_all");
    check_wr("fill_all", w0, 4, 8'h00, 8'h01, 8'h02, 8'h03);
    chk("fill_all_cnt", fcnt, 4);
    pulse_flush();

    // 2: counted fill, then zero count
    w0 = wr_log.size();
    send_byte(8'h6E, drop);
    chk("n_drop", drop, 0);
    send_byte(8'h03, drop);
    wait_idle("fill_n3");
    check_wr("fill_n3", w0, 3, 8'h00, 8'h01, 8'h02, 8'h00);
    pulse_flush();
    w0 = wr_log.size();
    send_byte(8'h6E, drop);
    send_byte(8'h00, drop);
    #1 chk("n0_busy", busy, 0);
    repeat (3) @(negedge clk_in);
    chk("n0_nwr", wr_log.size() - w0, 0);

    // 3: LFSR fill and clean check
    send_byte(8'h6D, drop);
    send_byte(8'h01, drop);
    w0 = wr_log.size();
    send_byte(8'h77, drop);
    wait_idle("lfsr");
    check_wr("lfsr", w0, 4, 8'h01, 8'hB8, 8'h5C, 8'h2E);
    t0 = tx_log.size(); p0 = pop_cnt;
    send_byte(8'h63, drop);
    wait_idle("chk_lfsr");
    chk("chk_lfsr_pops", pop_cnt - p0, 4);
    chk("chk_lfsr_ntx", tx_log.size() - t0, 1);
    if (tx_log.size() > t0) chk("chk_lfsr_tx", tx_log[t0], 8'h00);
    chk("chk_lfsr_err", err_count, 0);

    // 4: counter fill with one corrupted word
    send_byte(8'h6D, drop);
    send_byte(8'h00, drop);
    w0 = wr_log.size();
    send_byte(8'h6E, drop);
    send_byte(8'h04, drop);
    wait_idle("fill_n4");
    check_wr("fill_n4", w0, 4, 8'h00, 8'h01, 8'h02, 8'h03);
    @(negedge clk_in); tb_corrupt = 1'b1;
    @(negedge clk_in); tb_corrupt = 1'b0;
    t0 = tx_log.size();
    send_byte(8'h63, drop);
    wait_idle("chk_bad");
    chk("chk_bad_ntx", tx_log.size() - t0, 1);
    if (tx_log.size() > t0) chk("chk_bad_tx", tx_log[t0], 8'h01);
    chk("chk_bad_err", err_count, 1);

    // 5: drain with a toggling tx_ready
    send_byte(8'h77, drop);
    wait_idle("fill5");
    t0 = tx_log.size(); p0 = pop_cnt; r0 = nr_cnt;
    tog_en = 1'b1;
    send_byte(8'h72, drop);
    wait_idle("drain_tog");
    tog_en = 1'b0;
    chk("drain_tog_pops", pop_cnt - p0, 4);
    chk("drain_tog_nr", nr_cnt - r0, 0);
    chk("drain_tog_ntx", tx_log.size() - t0, 4);
    for (int i = 0; i < 4; i++)
      if (t0 + i < tx_log.size()) chk($sformatf("drain_tog_tx%0d", i), tx_log[t0+i], i);

    // 6: command while draining is dropped, unknown command dropped
    w0 = wr_log.size();
    send_byte(8'h77, drop);
    wait_idle("fill6");
    w0 = wr_log.size();
    t0 = tx_log.size();
    rdy_fix = 1'b0;
    send_byte(8'h72, drop);
    send_byte(8'h77, drop);
    chk("busy_drop", drop, 1);
    chk("busy_still", busy, 1);
    chk("busy_nwr", wr_log.size() - w0, 0);
    rdy_fix = 1'b1;
    wait_idle("drain6");
    chk("drain6_ntx", tx_log.size() - t0, 4);
    if (tx_log.size() > t0 + 3) chk("drain6_tx3", tx_log[t0+3], 8'h03);
    send_byte(8'h41, drop);
    chk("unk_drop", drop, 1);
    chk("unk_busy", busy, 0);

    // reset in the middle of a counted fill
    send_byte(8'h6E, drop);
    send_byte(8'h0A, drop);
    #1 chk("mid_wr_en", wr_en, 1);
    n_rst = 1'b0;
    #1 chk("mid_rst_outs", {tx_en, tx_data, wr_en, wr_data, rd_en, busy, cmd_drop, err_count}, 0);
    @(negedge clk_in); n_rst = 1'b1;
    pulse_flush();

    // counted fill larger than the FIFO stops at full
    w0 = wr_log.size();
    send_byte(8'h6E, drop);
    send_byte(8'h06, drop);
    wait_idle("fill_n6");
    check_wr("fill_n6", w0, 4, 8'h00, 8'h01, 8'h02, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
